// File: rtl/mem_stage_hs_pkg.sv
// rtl/mem_stage_hs_pkg.sv - shared encodings and zip widths for the MEM stage
package mem_stage_hs_pkg;

  typedef enum logic [3:0] {
    MEMOP_LD_B  = 4'd0,
    MEMOP_LD_H  = 4'd1,
    MEMOP_LD_W  = 4'd2,
    MEMOP_LD_D  = 4'd3,
    MEMOP_LD_BU = 4'd8,
    MEMOP_LD_HU = 4'd9,
    MEMOP_LD_WU = 4'd10
  } mem_op_e;

  // Control bits in each zip, excluding alu_result/rf_wdata and sideband.
  localparam int E2M_CTRL_W = 15;
  localparam int M2W_CTRL_W = 9;
  localparam int RF_CTRL_W  = 9;

  function automatic int exe2mem_w(input int xlen, input int side_w);
    return E2M_CTRL_W + xlen + side_w;
  endfunction

  function automatic int mem2wb_w(input int xlen, input int side_w);
    return M2W_CTRL_W + xlen + side_w;
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// rtl/mem_stage_hs_if.sv - EXE/WB/data-SRAM handshake bundle seen by the MEM stage
interface mem_stage_hs_if
  import mem_stage_hs_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SIDE_W = 144
);
  localparam int E2M_W = exe2mem_w(XLEN, SIDE_W);
  localparam int M2W_W = mem2wb_w(XLEN, SIDE_W);

  logic                      flush;
  logic                      exe_req_inflight;
  logic                      mem_allowin;
  logic                      exe_to_mem_valid;
  logic [E2M_W-1:0]          exe_to_mem_zip;
  logic                      wb_allowin;
  logic                      mem_to_wb_valid;
  logic [M2W_W-1:0]          mem_to_wb_zip;
  logic                      data_sram_data_ok;
  logic [XLEN-1:0]           data_sram_rdata;
  logic [XLEN+RF_CTRL_W-1:0] mem_rf_zip;
  logic                      mem_ex;

  modport master (
    output flush, exe_req_inflight, exe_to_mem_valid, exe_to_mem_zip,
           wb_allowin, data_sram_data_ok, data_sram_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex
  );

  modport slave (
    input  flush, exe_req_inflight, exe_to_mem_valid, exe_to_mem_zip,
           wb_allowin, data_sram_data_ok, data_sram_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex
  );

endinterface

// File: rtl/mem_stage_hs_load_align.sv
// rtl/mem_stage_hs_load_align.sv - combinational load lane select and sign/zero extension
module mem_stage_hs_load_align
  import mem_stage_hs_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [3:0]        mem_op,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   result
);

  logic [LANE_W-1:0] lane_h;
  logic [LANE_W-1:0] lane_w;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;

  always_comb begin
    lane_h = lane & ~LANE_W'(1);
    lane_w = lane & ~LANE_W'(3);
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = rdata[{lane_h, 3'b000} +: 16];
    word_v = rdata[{lane_w, 3'b000} +: 32];
  end

  // Doubleword ops only exist on the 64-bit datapath; elsewhere they read as 0.
  always_comb begin
    result = '0;
    case (mem_op)
      MEMOP_LD_B:  result = XLEN'($signed(byte_v));
      MEMOP_LD_H:  result = XLEN'($signed(half_v));
      MEMOP_LD_W:  result = XLEN'($signed(word_v));
      MEMOP_LD_D:  result = (XLEN == 64) ? rdata : '0;
      MEMOP_LD_BU: result = XLEN'(byte_v);
      MEMOP_LD_HU: result = XLEN'(half_v);
      MEMOP_LD_WU: result = (XLEN == 64) ? XLEN'(word_v) : '0;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM pipeline stage with data-SRAM response wait, hold buffer and flush discard
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_OUTST = 2,
  parameter int SIDE_W    = 144
) (
  input  logic          clk,
  input  logic          resetn,
  mem_stage_hs_if.slave bus
);

  localparam int E2M_W  = exe2mem_w(XLEN, SIDE_W);
  localparam int LANE_W = $clog2(XLEN / 8);
  localparam int CW     = $clog2(MAX_OUTST + 1);
  localparam int CW2    = CW + 2;

  logic             mem_valid;
  logic [E2M_W-1:0] e2m_q;
  logic             buf_valid;
  logic [XLEN-1:0]  rdata_buf;
  logic [CW-1:0]    cnt;

  logic              req_sent;
  logic              res_from_mem;
  logic [3:0]        mem_op;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic              csr_read;
  logic              ex_valid;
  logic              is_ertn;
  logic [XLEN-1:0]   alu_result;
  logic [SIDE_W-1:0] side;

  assign {req_sent, res_from_mem, mem_op, rf_we, rf_waddr,
          csr_read, ex_valid, is_ertn, alu_result, side} = e2m_q;

  logic need_resp;
  logic resp_hit;
  logic resp_drop;
  logic ready_go;
  logic to_wb_valid;
  logic leave;
  logic load_in;

  assign need_resp   = mem_valid & req_sent;
  assign resp_hit    = bus.data_sram_data_ok & (cnt == '0) & need_resp & ~buf_valid;
  assign resp_drop   = bus.data_sram_data_ok & (cnt != '0);
  assign ready_go    = ~need_resp | buf_valid | resp_hit;
  assign to_wb_valid = mem_valid & ready_go & ~bus.flush;
  assign leave       = to_wb_valid & bus.wb_allowin;
  assign load_in     = bus.exe_to_mem_valid & bus.mem_allowin;

  assign bus.mem_allowin     = ~mem_valid | (ready_go & bus.wb_allowin);
  assign bus.mem_to_wb_valid = to_wb_valid;

  // Responses still owed to flushed work: the stranded MEM access plus one EXE already issued.
  logic [CW2-1:0] cnt_inc;
  logic [CW2-1:0] cnt_nxt;

  always_comb begin
    cnt_inc = '0;
    if (bus.flush) begin
      cnt_inc = CW2'(need_resp & ~buf_valid & ~resp_hit) + CW2'(bus.exe_req_inflight);
    end
    cnt_nxt = {2'b00, cnt} + cnt_inc - CW2'(resp_drop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      buf_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (bus.flush) begin
        mem_valid <= 1'b0;
      end else if (bus.mem_allowin) begin
        mem_valid <= bus.exe_to_mem_valid;
      end
      if (leave || bus.flush) begin
        buf_valid <= 1'b0;
      end else if (resp_hit) begin
        buf_valid <= 1'b1;
      end
      cnt <= cnt_nxt[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (load_in) begin
      e2m_q <= bus.exe_to_mem_zip;
    end
    if (resp_hit) begin
      rdata_buf <= bus.data_sram_rdata;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
    cnt_nxt <= CW2'(MAX_OUTST));

  logic [XLEN-1:0] rdata_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] rf_wdata;

  assign rdata_sel = buf_valid ? rdata_buf : bus.data_sram_rdata;

  mem_stage_hs_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .mem_op (mem_op),
    .lane   (alu_result[LANE_W-1:0]),
    .rdata  (rdata_sel),
    .result (load_data)
  );

  assign rf_wdata = res_from_mem ? load_data : alu_result;

  assign bus.mem_to_wb_zip = {rf_we, rf_waddr, rf_wdata, csr_read, ex_valid, is_ertn, side};

  // ID may only forward rf_wdata once the value is final (fwd_ready).
  assign bus.mem_rf_zip = {mem_valid & ready_go,
                           csr_read & mem_valid,
                           res_from_mem & mem_valid,
                           rf_we & mem_valid,
                           rf_waddr,
                           rf_wdata};

  assign bus.mem_ex = mem_valid & (ex_valid | is_ertn);

endmodule
